// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the MEM-stage access sequencer.
// The misalignment helper is only referenced when MEM_MISALIGN_TRAP_EN is defined.
package mem_stage_ctrl_pkg;

   localparam int MATRIX_WORDS_DEF = 4;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {IDLE, SCALAR, MAT_RD, MAT_WR, DONE} state_t;

   typedef enum logic [2:0] {OP_NONE, OP_LOAD, OP_STORE, OP_MAT_RD, OP_MAT_WR} op_t;

   // Store encodings 100/101 are not defined and fall back to word handling.
   function automatic logic misaligned(input op_t op, input logic [2:0] f3, input logic [1:0] lo);
      logic m;
      m = 1'b0;
      case (op)
         OP_MAT_RD, OP_MAT_WR: m = (lo != 2'b00);
         OP_LOAD: begin
            case (f3)
               F3_B, F3_BU: m = 1'b0;
               F3_H, F3_HU: m = lo[0];
               F3_W:        m = (lo != 2'b00);
               default:     m = (lo != 2'b00);
            endcase
         end
         OP_STORE: begin
            case (f3)
               F3_B:    m = 1'b0;
               F3_H:    m = lo[0];
               default: m = (lo != 2'b00);
            endcase
         end
         default: m = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane logic for scalar accesses: store byte enables and lane replication,
// load byte/half extraction with sign or zero extension.
module mem_lane_align
   import mem_stage_ctrl_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [1:0]          st_lane,
   input  logic [2:0]          st_f3,
   input  logic [DATA_W-1:0]   st_data,
   output logic [DATA_W/8-1:0] st_be,
   output logic [DATA_W-1:0]   st_wdata,
   input  logic [1:0]          ld_lane,
   input  logic [2:0]          ld_f3,
   input  logic [DATA_W-1:0]   ld_rdata,
   output logic [DATA_W-1:0]   ld_data
);
   localparam int NB = DATA_W / 8;
   localparam logic [NB-1:0] BE_B = NB'(1);
   localparam logic [NB-1:0] BE_H = NB'(3);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign ld_byte = ld_rdata[{ld_lane, 3'b000} +: 8];
   assign ld_half = ld_rdata[{ld_lane[1], 4'b0000} +: 16];

   always_comb begin
      st_be    = '1;
      st_wdata = st_data;
      case (st_f3)
         F3_B: begin
            st_be    = BE_B << st_lane;
            st_wdata = {NB{st_data[7:0]}};
         end
         F3_H: begin
            st_be    = BE_H << st_lane;
            st_wdata = {(NB/2){st_data[15:0]}};
         end
         F3_W:    st_be = '1;
         default: st_be = '1;
      endcase
   end

   always_comb begin
      ld_data = ld_rdata;
      case (ld_f3)
         F3_B:    ld_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
         F3_BU:   ld_data = {{(DATA_W-8){1'b0}}, ld_byte};
         F3_H:    ld_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
         F3_HU:   ld_data = {{(DATA_W-16){1'b0}}, ld_half};
         F3_W:    ld_data = ld_rdata;
         default: ld_data = ld_rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: scalar and matrix row/line accesses over a req/ready port.
// Define MEM_MISALIGN_TRAP_EN to flag misaligned accesses instead of issuing them.
module mem_stage_ctrl
   import mem_stage_ctrl_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int MATRIX_WORDS = MATRIX_WORDS_DEF
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [DATA_W-1:0]              me_alu_o,
   input  logic [DATA_W-1:0]              me_regs_data2,
   input  logic [MATRIX_WORDS*DATA_W-1:0] me_matrix_mul_o,
   input  logic [2:0]                     me_func3_code,
   input  logic                           me_mem_read,
   input  logic                           me_mem_write,
   input  logic                           me_matrix2mem,
   input  logic                           me_mem2matrix,
   output logic                           dmem_req,
   output logic                           dmem_we,
   output logic [DATA_W-1:0]              dmem_addr,
   output logic [DATA_W-1:0]              dmem_wdata,
   output logic [DATA_W/8-1:0]            dmem_be,
   input  logic                           dmem_ready,
   input  logic [DATA_W-1:0]              dmem_rdata,
   output logic                           mem_stall,
   output logic                           mem_done,
   output logic [DATA_W-1:0]              mem_load_data,
   output logic [MATRIX_WORDS*DATA_W-1:0] mem_line_data,
   output logic                           mem_misalign
);
   localparam int CNT_W = $clog2(MATRIX_WORDS);
   localparam logic [CNT_W-1:0]  LAST      = CNT_W'(MATRIX_WORDS - 1);
   localparam logic [DATA_W-1:0] WORD_STEP = DATA_W'(DATA_W / 8);

   state_t state, nxt;
   op_t    op_sel;
   logic   op_any, xfer, last, mis;

   logic [CNT_W-1:0]                     cnt;
   logic [2:0]                           f3_q;
   logic [1:0]                           lane_q;
   logic [MATRIX_WORDS-1:0][DATA_W-1:0]  mat_in, mat_q, line_buf, line_nxt;
   logic [DATA_W/8-1:0]                  st_be;
   logic [DATA_W-1:0]                    st_wdata, ld_data;

   assign mat_in = me_matrix_mul_o;
   assign xfer   = dmem_req && dmem_ready;
   assign last   = (cnt == LAST);

   always_comb begin
      op_sel = OP_NONE;
      if      (me_matrix2mem) op_sel = OP_MAT_WR;
      else if (me_mem2matrix) op_sel = OP_MAT_RD;
      else if (me_mem_write)  op_sel = OP_STORE;
      else if (me_mem_read)   op_sel = OP_LOAD;
   end

   // Qualified by reset so stall stays low while reset is held.
   assign op_any = rst && (op_sel != OP_NONE);

`ifdef MEM_MISALIGN_TRAP_EN
   logic mis_q;

   assign mis = misaligned(op_sel, me_func3_code, me_alu_o[1:0]);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                         mis_q <= 1'b0;
      else if (state == IDLE && op_any) mis_q <= mis;
   end

   assign mem_misalign = (state == DONE) && mis_q;
`else
   assign mis          = 1'b0;
   assign mem_misalign = 1'b0;
`endif

   // Store side sees the live EX/MEM operands; load side the registered ones.
   mem_lane_align #(.DATA_W(DATA_W)) u_align (
      .st_lane  (me_alu_o[1:0]),
      .st_f3    (me_func3_code),
      .st_data  (me_regs_data2),
      .st_be    (st_be),
      .st_wdata (st_wdata),
      .ld_lane  (lane_q),
      .ld_f3    (f3_q),
      .ld_rdata (dmem_rdata),
      .ld_data  (ld_data)
   );

   always_comb begin
      line_nxt      = line_buf;
      line_nxt[cnt] = dmem_rdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nxt;
   end

   always_comb begin
      nxt       = state;
      mem_stall = 1'b0;
      mem_done  = 1'b0;
      case (state)
         IDLE: begin
            if (op_any) begin
               mem_stall = 1'b1;
               if (mis) nxt = DONE;
               else begin
                  case (op_sel)
                     OP_MAT_WR: nxt = MAT_WR;
                     OP_MAT_RD: nxt = MAT_RD;
                     default:   nxt = SCALAR;
                  endcase
               end
            end
         end
         SCALAR: begin
            mem_stall = 1'b1;
            if (xfer) nxt = DONE;
         end
         MAT_RD, MAT_WR: begin
            mem_stall = 1'b1;
            if (xfer && last) nxt = DONE;
         end
         DONE: begin
            mem_done = 1'b1;
            nxt      = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dmem_req      <= 1'b0;
         dmem_we       <= 1'b0;
         dmem_addr     <= '0;
         dmem_wdata    <= '0;
         dmem_be       <= '0;
         cnt           <= '0;
         f3_q          <= '0;
         lane_q        <= '0;
         mat_q         <= '0;
         line_buf      <= '0;
         mem_load_data <= '0;
         mem_line_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (op_any) begin
                  f3_q   <= me_func3_code;
                  lane_q <= me_alu_o[1:0];
                  mat_q  <= mat_in;
                  cnt    <= '0;
                  if (!mis) begin
                     dmem_req  <= 1'b1;
                     dmem_addr <= {me_alu_o[DATA_W-1:2], 2'b00};
                     case (op_sel)
                        OP_MAT_WR: begin
                           dmem_we    <= 1'b1;
                           dmem_be    <= '1;
                           dmem_wdata <= mat_in[0];
                        end
                        OP_MAT_RD: begin
                           dmem_we    <= 1'b0;
                           dmem_be    <= '1;
                           dmem_wdata <= '0;
                           line_buf   <= '0;
                        end
                        OP_STORE: begin
                           dmem_we    <= 1'b1;
                           dmem_be    <= st_be;
                           dmem_wdata <= st_wdata;
                        end
                        default: begin
                           dmem_we    <= 1'b0;
                           dmem_be    <= '1;
                           dmem_wdata <= '0;
                        end
                     endcase
                  end
               end
            end
            SCALAR: begin
               if (xfer) begin
                  dmem_req <= 1'b0;
                  if (!dmem_we) mem_load_data <= ld_data;
               end
            end
            MAT_WR, MAT_RD: begin
               if (xfer) begin
                  if (state == MAT_RD) line_buf <= line_nxt;
                  if (last) begin
                     dmem_req <= 1'b0;
                     if (state == MAT_RD) mem_line_data <= line_nxt;
                  end else begin
                     cnt       <= cnt + CNT_W'(1);
                     dmem_addr <= dmem_addr + WORD_STEP;
                     if (state == MAT_WR) dmem_wdata <= mat_q[cnt + CNT_W'(1)];
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: directed ops, a ready-pattern responder,
// and monitors that check each memory transfer and each completion pulse.
module tb_mem_stage_ctrl;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [31:0]  me_alu_o, me_regs_data2;
   logic [127:0] me_matrix_mul_o;
   logic [2:0]   me_func3_code;
   logic         me_mem_read, me_mem_write, me_matrix2mem, me_mem2matrix;
   logic         dmem_req, dmem_we;
   logic [31:0]  dmem_addr, dmem_wdata;
   logic [3:0]   dmem_be;
   logic         dmem_ready = 1'b0;
   logic [31:0]  dmem_rdata = 32'h0;
   logic         mem_stall, mem_done, mem_misalign;
   logic [31:0]  mem_load_data;
   logic [127:0] mem_line_data;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } req_t;

   typedef struct packed {
      logic [31:0]  load;
      logic [127:0] line;
      logic         mis;
   } rsp_t;

   req_t        req_q[$];
   rsp_t        rsp_q[$];
   logic [31:0] rd_q[$];

   int total = 0;
   int bad   = 0;
   int xfers = 0;
   int delay = 0;
   int wcnt  = 0;
   bit tog   = 1'b0;
   bit idle_rdy = 1'b0;

   logic [31:0]  exp_load = 32'h0;
   logic [127:0] exp_line = 128'h0;

   mem_stage_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .me_alu_o        (me_alu_o),
      .me_regs_data2   (me_regs_data2),
      .me_matrix_mul_o (me_matrix_mul_o),
      .me_func3_code   (me_func3_code),
      .me_mem_read     (me_mem_read),
      .me_mem_write    (me_mem_write),
      .me_matrix2mem   (me_matrix2mem),
      .me_mem2matrix   (me_mem2matrix),
      .dmem_req        (dmem_req),
      .dmem_we         (dmem_we),
      .dmem_addr       (dmem_addr),
      .dmem_wdata      (dmem_wdata),
      .dmem_be         (dmem_be),
      .dmem_ready      (dmem_ready),
      .dmem_rdata      (dmem_rdata),
      .mem_stall       (mem_stall),
      .mem_done        (mem_done),
      .mem_load_data   (mem_load_data),
      .mem_line_data   (mem_line_data),
      .mem_misalign    (mem_misalign)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic exp_req(input logic [31:0] a, input logic we, input logic [3:0] be,
                          input logic [31:0] wd);
      req_t r;
      r.addr = a; r.we = we; r.be = be; r.wdata = wd;
      req_q.push_back(r);
   endtask

   task automatic exp_rsp(input logic mis);
      rsp_t r;
      r.load = exp_load; r.line = exp_line; r.mis = mis;
      rsp_q.push_back(r);
   endtask

   // Responder drives ready at negedge; request monitor checks each transfer.
   always begin : resp
      req_t e;
      @(negedge clk);
      if (!dmem_req) begin
         dmem_ready = idle_rdy;
         wcnt       = 0;
      end else if (tog) begin
         dmem_ready = !dmem_ready;
      end else if (wcnt >= delay) begin
         dmem_ready = 1'b1;
      end else begin
         dmem_ready = 1'b0;
         wcnt++;
      end
      dmem_rdata = (rd_q.size() > 0) ? rd_q[0] : 32'h0;
      #2;
      if (rst && dmem_req && dmem_ready) begin
         xfers++;
         wcnt = 0;
         if (req_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_req: addr %0h we %0b with no request expected", dmem_addr, dmem_we);
         end else begin
            e = req_q.pop_front();
            chk("req_addr", dmem_addr, e.addr);
            chk("req_we", dmem_we, e.we);
            chk("req_be", dmem_be, e.be);
            if (e.we) chk("req_wdata", dmem_wdata, e.wdata);
         end
         if (rd_q.size() > 0) void'(rd_q.pop_front());
      end
   end

   always begin : done_mon
      rsp_t r;
      @(negedge clk);
      #1;
      if (mem_done) begin
         chk("done_stall", mem_stall, 1'b0);
         chk("done_req", dmem_req, 1'b0);
         if (rsp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: load %0h with no completion expected", mem_load_data);
         end else begin
            r = rsp_q.pop_front();
            chk("done_load", mem_load_data, r.load);
            chk("done_line", mem_line_data, r.line);
            chk("done_mis", mem_misalign, r.mis);
         end
      end
   end

   // Called at posedge+1; holds EX/MEM inputs until the DONE cycle has passed.
   task automatic run_op(input string nm, input logic [3:0] fl, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f3, input logic [127:0] m,
                         input int exp_stall, input int exp_rq);
      int st = 0;
      int rq = 0;
      bit got = 1'b0;
      {me_matrix2mem, me_mem2matrix, me_mem_write, me_mem_read} = fl;
      me_alu_o = a; me_regs_data2 = d; me_func3_code = f3; me_matrix_mul_o = m;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         #1;
         if (mem_stall) st++;
         if (dmem_req)  rq++;
         if (mem_done)  got = 1'b1;
         @(posedge clk);
         #1;
      end
      {me_matrix2mem, me_mem2matrix, me_mem_write, me_mem_read} = 4'b0000;
      chk({nm, "_done_seen"}, got, 1'b1);
      chk({nm, "_stall_cycles"}, st, exp_stall);
      chk({nm, "_req_cycles"}, rq, exp_rq);
      chk({nm, "_reqs_left"}, req_q.size(), 0);
      @(negedge clk);
      #1;
      chk({nm, "_done_once"}, mem_done, 1'b0);
      chk({nm, "_idle_stall"}, mem_stall, 1'b0);
      @(posedge clk);
      #1;
   endtask

   initial begin : main
      int x0;
      me_alu_o = 0; me_regs_data2 = 0; me_matrix_mul_o = 0; me_func3_code = 0;
      {me_matrix2mem, me_mem2matrix, me_mem_write, me_mem_read} = 4'b0000;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctrl", {dmem_req, dmem_we, dmem_be, mem_stall, mem_done, mem_misalign}, 0);
      chk("rst_addr", {dmem_addr, dmem_wdata}, 0);
      chk("rst_load", mem_load_data, 0);
      chk("rst_line", mem_line_data, 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // LB at 0x103, ready after two wait cycles
      delay = 2;
      exp_req(32'h100, 1'b0, 4'hF, 32'h0);
      rd_q.push_back(32'h80FF_1234);
      exp_load = 32'hFFFF_FF80;
      exp_rsp(1'b0);
      run_op("lb", 4'b0001, 32'h103, 32'h0, 3'b000, 128'h0, 4, 3);
      delay = 0;

      exp_req(32'h200, 1'b1, 4'b1100, 32'hABCD_ABCD);
      exp_rsp(1'b0);
      run_op("sh", 4'b0010, 32'h202, 32'h0000_ABCD, 3'b001, 128'h0, 2, 1);

      exp_req(32'h100, 1'b0, 4'hF, 32'h0);
      rd_q.push_back(32'h80FF_1234);
      exp_load = 32'h0000_80FF;
      exp_rsp(1'b0);
      run_op("lhu", 4'b0001, 32'h102, 32'h0, 3'b101, 128'h0, 2, 1);

      exp_req(32'h100, 1'b0, 4'hF, 32'h0);
      rd_q.push_back(32'h1234_8001);
      exp_load = 32'hFFFF_8001;
      exp_rsp(1'b0);
      run_op("lh", 4'b0001, 32'h100, 32'h0, 3'b001, 128'h0, 2, 1);

      exp_req(32'h100, 1'b0, 4'hF, 32'h0);
      rd_q.push_back(32'h0000_9A00);
      exp_load = 32'h0000_009A;
      exp_rsp(1'b0);
      run_op("lbu", 4'b0001, 32'h101, 32'h0, 3'b100, 128'h0, 2, 1);

      exp_req(32'h300, 1'b1, 4'b0010, 32'h5A5A_5A5A);
      exp_rsp(1'b0);
      run_op("sb", 4'b0010, 32'h301, 32'h1234_565A, 3'b000, 128'h0, 2, 1);

      exp_req(32'h300, 1'b1, 4'hF, 32'hCAFE_F00D);
      exp_rsp(1'b0);
      run_op("sw", 4'b0010, 32'h300, 32'hCAFE_F00D, 3'b010, 128'h0, 2, 1);

      // read and write together: the store wins
      exp_req(32'h304, 1'b1, 4'hF, 32'h0102_0304);
      exp_rsp(1'b0);
      run_op("prio_wr", 4'b0011, 32'h304, 32'h0102_0304, 3'b010, 128'h0, 2, 1);

      // matrix store with ready toggling 1/0
      tog = 1'b1;
      for (int i = 0; i < 4; i++) exp_req(32'h400 + 4 * i, 1'b1, 4'hF, i + 1);
      exp_rsp(1'b0);
      run_op("mat_wr", 4'b1000, 32'h400, 32'h0,
             3'b000, {32'd4, 32'd3, 32'd2, 32'd1}, 8, 7);
      tog = 1'b0;

      for (int i = 0; i < 4; i++) begin
         exp_req(32'h800 + 4 * i, 1'b0, 4'hF, 32'h0);
         rd_q.push_back(32'hA0 + i);
      end
      exp_line = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      exp_rsp(1'b0);
      run_op("mat_rd", 4'b0100, 32'h800, 32'h0, 3'b000, 128'h0, 5, 4);

      // all flags set: matrix store has top priority
      for (int i = 0; i < 4; i++) exp_req(32'h500 + 4 * i, 1'b1, 4'hF, 32'h50 + i);
      exp_rsp(1'b0);
      run_op("prio_mat", 4'b1111, 32'h500, 32'h0,
             3'b000, {32'h53, 32'h52, 32'h51, 32'h50}, 5, 4);

      // misaligned LW with ready asserted while no request is out
      idle_rdy = 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
      exp_rsp(1'b1);
      run_op("lw_mis", 4'b0001, 32'h102, 32'h0, 3'b010, 128'h0, 1, 0);
`else
      exp_req(32'h100, 1'b0, 4'hF, 32'h0);
      rd_q.push_back(32'h1122_3344);
      exp_load = 32'h1122_3344;
      exp_rsp(1'b0);
      run_op("lw_mis", 4'b0001, 32'h102, 32'h0, 3'b010, 128'h0, 2, 1);
`endif
      idle_rdy = 1'b0;

      // unlisted func3 on a load behaves as a word
      exp_req(32'h104, 1'b0, 4'hF, 32'h0);
      rd_q.push_back(32'hDEAD_BEEF);
      exp_load = 32'hDEAD_BEEF;
      exp_rsp(1'b0);
      run_op("f3_111", 4'b0001, 32'h104, 32'h0, 3'b111, 128'h0, 2, 1);

      // reset while word 2 of a matrix load is pending
      delay = 2;
      x0 = xfers;
      for (int i = 0; i < 4; i++) begin
         exp_req(32'h900 + 4 * i, 1'b0, 4'hF, 32'h0);
         rd_q.push_back(32'hC0 + i);
      end
      me_mem2matrix = 1'b1;
      me_alu_o      = 32'h900;
      for (int i = 0; i < 100 && xfers < x0 + 2; i++) begin
         @(negedge clk);
         #3;
      end
      chk("rst_mid_two_words", xfers - x0, 2);
      @(posedge clk);
      #2;
      chk("rst_mid_req_pending", {dmem_req, dmem_addr}, {1'b1, 32'h908});
      rst = 1'b0;
      #1;
      chk("rst_mid_req_drop", dmem_req, 1'b0);
      chk("rst_mid_stall", {mem_stall, mem_done}, 2'b00);
      chk("rst_mid_line", mem_line_data, 0);
      chk("rst_mid_load", mem_load_data, 0);
      me_mem2matrix = 1'b0;
      req_q.delete();
      rd_q.delete();
      exp_load = 32'h0;
      exp_line = 128'h0;
      delay = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 4; i++) begin
         exp_req(32'hC00 + 4 * i, 1'b0, 4'hF, 32'h0);
         rd_q.push_back(32'hB0 + i);
      end
      exp_line = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
      exp_rsp(1'b0);
      run_op("mat_rd_after_rst", 4'b0100, 32'hC00, 32'h0, 3'b000, 128'h0, 5, 4);

      chk("rsp_left", rsp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $fatal(1);
   end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage access sequencer. Consumes the EX/MEM pipeline register outputs and drives a req/ready data-memory port.
- Handles scalar loads/stores: byte, half or word, with sign or zero extension.
- Handles matrix row stores: MATRIX_WORDS words from the matrix-multiply result. Handles matrix line loads: MATRIX_WORDS words into a line buffer.
- Stalls the pipeline while an access is outstanding and presents results to the MEM/WB register.

Parameters:
- DATA_W, 32, data and address width.
- MATRIX_WORDS, 4, words per matrix row or line transfer. Must be a power of two and ≥2.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- me_alu_o  in  32  effective address
- me_regs_data2  in  32  scalar store data
- me_matrix_mul_o  in  128  flattened matrix result; word i = bits [32i+31:32i]
- me_func3_code  in  3  access size/sign
- me_mem_read  in  1  scalar load
- me_mem_write  in  1  scalar store
- me_matrix2mem  in  1  matrix row store
- me_mem2matrix  in  1  matrix line load
- dmem_req  out  1  request valid
- dmem_we  out  1  write enable
- dmem_addr  out  32  word-aligned address (bits [1:0]=0)
- dmem_wdata  out  32  lane-aligned write data
- dmem_be  out  4  byte enables
- dmem_ready  in  1  handshake; read data valid in the same cycle
- dmem_rdata  in  32  read data
- mem_stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM
- mem_done  out  1  one-cycle pulse: access complete, results valid
- mem_load_data  out  32  extended scalar load result
- mem_line_data  out  128  assembled matrix line
- mem_misalign  out  1  misaligned-access flag (optional feature only)

Behaviour:
- States: IDLE, SCALAR, MAT_RD, MAT_WR, DONE.
- Reset: async to IDLE, effective immediately, including mid-transfer. On reset all outputs are 0, the word counter is 0, and the line buffer is 0. No partial result survives reset.
- Operation priority when several flags are set: matrix2mem > mem2matrix > mem_write > mem_read.
- IDLE with an operation present:
  - Register the op, address and data.
  - Go to MAT_WR, MAT_RD or SCALAR.
  - mem_stall=1 combinationally in that same cycle.
- IDLE with no operation: mem_stall=0.
- mem_stall=1 in SCALAR, MAT_RD and MAT_WR. mem_stall=0 in DONE and in IDLE with no op.
- dmem_req is a registered output. It is held with stable addr/wdata/be/we until a cycle where dmem_req && dmem_ready; that cycle is the transfer.
- SCALAR:
  - Loads: dmem_be=4'b1111. On transfer, mem_load_data is selected by addr[1:0] and func3. 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU, 101 LHU.
  - Stores: func3 000/001/010 give be = 0001<<a, 0011<<a, 1111. Data is replicated into all lanes.
  - On transfer → DONE.
- MAT_WR:
  - Word i is written to addr_base + 4i, with be=1111 and wdata = matrix word i, for i = 0..MATRIX_WORDS-1.
  - The counter increments on each transfer. After the last transfer → DONE.
- MAT_RD:
  - Same address sequence. On each transfer, dmem_rdata is stored into line word i.
  - After the last transfer → DONE, and mem_line_data becomes valid.
- Matrix base address: addr_base = me_alu_o with bits [1:0] forced to 0.
- DONE: mem_done=1 for exactly one cycle, dmem_req=0, stall released, then → IDLE unconditionally.
  - The pipeline advances at the end of DONE, so the same instruction is never re-issued. Each instruction costs ≥2 extra cycles.
- mem_load_data and mem_line_data hold their value until the next completing access of the same kind.
- dmem_ready while dmem_req=0 is ignored.
- func3 codes not listed above are treated as word accesses.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- When defined:
  - A scalar LH/LHU/SH with addr[0]=1, or an LW/SW with addr[1:0]≠0, issues no request. The block goes IDLE→DONE directly with mem_misalign=1 during DONE and mem_load_data unchanged.
  - A matrix access with addr[1:0]≠0 is flagged the same way.
- When undefined: addresses are used unchecked (the low bits select lanes only), and mem_misalign is tied to 0.

Decomposition:
- Shared package holds:
  - State enum encodings.
  - func3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - MATRIX_WORDS default.
- Sub-module mem_lane_align (combinational): byte-enable generation, store lane replication, and load extraction/extension. The FSM, counter and line buffer stay in mem_stage_ctrl.

Test Plan:
- LB at 0x103 with rdata=0x80FF_1234 and ready after 2 cycles → one req held 3 cycles; mem_load_data=0xFFFF_FF80; mem_done pulses once; stall spans exactly IDLE + SCALAR cycles.
- SH at 0x202 with data=0x0000_ABCD → addr=0x200, be=1100, wdata=0xABCD_ABCD; ready immediate → DONE on the next cycle.
- Matrix store base 0x400, words {1,2,3,4}, ready toggling 1/0 → writes 0x400/404/408/40C in order with matching data; no duplicate or skipped word.
- Matrix load base 0x800, rdata 0xA0..0xA3 → mem_line_data=0x000000A3_000000A2_000000A1_000000A0; stall released only in DONE.
- rst asserted while word 2 of a matrix load is pending → req drops asynchronously; next op restarts at word 0 with the line buffer cleared.
- With MEM_MISALIGN_TRAP_EN: LW at 0x102 → no dmem_req; mem_misalign=1 and mem_done=1 in the same cycle. Without it: req at addr 0x100.
